led_mode_scheduler: RTL and testbench
=====================================

Name: led_mode_scheduler

Overview:
- Top-level sequencer for the LED pattern drivers (heart-beat, flow, breathing, etc.).
- Selects one of NUM_MODES driver outputs for the 8 board LEDs. It holds every non-selected driver in reset.
- Advances the mode on a debounced button press or on an auto-cycle timer.
- Inserts a blanking gap at every mode switch so each pattern restarts from its first step.

Parameters:
- NUM_MODES, 4, number of LED driver instances multiplexed (2..8).
- DEBOUNCE, 2400, consecutive clk cycles a synchronized button level must hold before it is accepted.
- BLANK, 240, clk cycles of forced-dark LEDs and all-drivers-reset after a mode switch (>=1).
- AUTO_PERIOD, 960000, clk cycles per mode in auto-cycle mode (>=2).
- MW, derived = max(1, clog2(NUM_MODES)), width of mode_sel.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- btn_next  in  1  raw push-button, active-high, asynchronous to clk, bouncy.
- auto_en  in  1  synchronous level; 1 = auto-cycle modes.
- mode_led_in  in  8*NUM_MODES  packed driver outputs; mode i occupies bits [8i+7:8i].
- mode_rst_n  out  NUM_MODES  per-driver active-low reset; bit i feeds driver i.
- mode_sel  out  MW  currently selected mode index.
- led_out  out  8  LED drive, registered.
- mode_changed  out  1  one-cycle pulse when mode_sel advances.

Behaviour:
- Reset (async, rst_n=0):
  - state=BLANK, mode_sel=0, led_out=0, mode_rst_n=all 0, mode_changed=0.
  - All counters = 0; debounced button level = 0; synchronizer flops = 0.
- Button path:
  - 2-flop synchronizer, then the debouncer.
  - Debouncer: the counter increments while the synced value differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE-1 while still differing, the debounced level takes the synced value and the counter clears.
  - btn_req = 1-cycle pulse on a 0->1 transition of the debounced level.
  - Press-and-hold yields exactly one request; release yields none.
- Auto path:
  - The auto counter runs only while state=RUN and auto_en=1.
  - At count AUTO_PERIOD-1 it pulses auto_req and wraps to 0.
  - It clears when auto_en=0 and on every mode switch.
- next_req = btn_req OR auto_req. A simultaneous button and auto request causes a single advance.
- State BLANK:
  - led_out=0 and mode_rst_n=all 0.
  - The blank counter counts 0..BLANK-1, then state goes to RUN and the blank counter clears.
  - next_req during BLANK is discarded, not queued.
- State RUN:
  - mode_rst_n = one-hot of mode_sel (only the selected driver released).
  - led_out(t+1) = mode_led_in[8*mode_sel(t)+:8]. One-cycle latency, registered.
- On next_req in RUN:
  - mode_sel <= (mode_sel==NUM_MODES-1) ? 0 : mode_sel+1.
  - state <= BLANK; mode_changed=1 for exactly that next cycle.
  - From the next cycle, led_out=0 and mode_rst_n=all 0.
- First RUN after reset is mode 0, reached BLANK cycles after rst_n deasserts.
- Reset mid-BLANK or mid-RUN returns immediately to the reset values; pending debounce or auto counts are lost.
- mode_sel never takes values >= NUM_MODES.
- All outputs come from flops; no combinational path from inputs to outputs.

Test Plan (NUM_MODES=3, DEBOUNCE=4, BLANK=3, AUTO_PERIOD=20):
- Release rst_n with auto_en=0 and mode_led_in={8'h33,8'h22,8'h11}:
  - led_out=0 and mode_rst_n=3'b000 for 3 cycles.
  - Then mode_rst_n=3'b001, and led_out=8'h11 one cycle later.
- btn_next toggles every 2 cycles for 10 cycles, then stays high 10 cycles:
  - Exactly one mode_changed pulse; mode_sel=1.
  - Blank of 3 cycles, then led_out=8'h22 and mode_rst_n=3'b010.
  - Holding the button longer gives no further change.
- auto_en=1 from RUN in mode 0:
  - mode_changed fires every 20+3 cycles.
  - mode_sel sequence is 1,2,0,1 (wrap-around checked).
- Debounced button edge lands on the same cycle as auto count 19:
  - A single advance (mode_sel +1, not +2) and one mode_changed pulse.
- Button edge accepted during BLANK: ignored; mode_sel unchanged after RUN resumes.
- Assert rst_n=0 during BLANK after reaching mode 2:
  - Outputs return immediately to the reset values, and mode_sel=0.
  - Recovery repeats the first scenario.

Source files
------------

// File: rtl/led_mode_scheduler_if.sv
// LED driver bus between the mode scheduler and the pattern drivers it multiplexes.
// The scheduler takes the slave side; the board/driver side takes the master side.
interface led_mode_scheduler_if #(
  parameter int unsigned NUM_MODES = 4
);
  localparam int unsigned MW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;

  logic [8*NUM_MODES-1:0] mode_led_in;
  logic [NUM_MODES-1:0]   mode_rst_n;
  logic [MW-1:0]          mode_sel;
  logic [7:0]             led_out;
  logic                   mode_changed;

  modport master (
    output mode_led_in,
    input  mode_rst_n,
    input  mode_sel,
    input  led_out,
    input  mode_changed
  );

  modport slave (
    input  mode_led_in,
    output mode_rst_n,
    output mode_sel,
    output led_out,
    output mode_changed
  );
endinterface

// File: rtl/led_mode_scheduler.sv
// Sequences the LED pattern drivers: selects one driver, holds the rest in reset, and
// advances on a debounced button press or auto-cycle timeout with a blanking gap.
module led_mode_scheduler #(
  parameter int unsigned NUM_MODES   = 4,
  parameter int unsigned DEBOUNCE    = 2400,
  parameter int unsigned BLANK       = 240,
  parameter int unsigned AUTO_PERIOD = 960000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_next,
  input  logic                 auto_en,
  led_mode_scheduler_if.slave  bus
);
  localparam int unsigned MW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
  localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam int unsigned AW = $clog2(AUTO_PERIOD);

  typedef enum logic {StBlank, StRun} state_e;

  state_e               r_state;
  logic                 r_sync1, r_sync2;
  logic                 r_db, r_db_prev;
  logic [DW-1:0]        r_db_cnt;
  logic [AW-1:0]        r_auto_cnt;
  logic [BW-1:0]        r_blank_cnt;
  logic [MW-1:0]        r_sel;
  logic [7:0]           r_led;
  logic [NUM_MODES-1:0] r_rst_n;
  logic                 r_chg;

  logic                 w_run;
  logic                 w_btn_req;
  logic                 w_auto_req;
  logic                 w_next_req;
  logic [MW-1:0]        w_sel_next;
  logic [NUM_MODES-1:0] w_onehot;
  logic [7:0]           w_led_sel;

  assign w_run      = (r_state == StRun);
  assign w_btn_req  = r_db & ~r_db_prev;
  assign w_auto_req = w_run && auto_en && (r_auto_cnt == AW'(AUTO_PERIOD - 1));
  // Requests outside RUN are dropped, never queued.
  assign w_next_req = w_run && (w_btn_req || w_auto_req);
  assign w_sel_next = (r_sel == MW'(NUM_MODES - 1)) ? '0 : r_sel + 1'b1;
  assign w_onehot   = NUM_MODES'(1) << r_sel;

  always_comb begin
    w_led_sel = '0;
    for (int i = 0; i < int'(NUM_MODES); i++) begin
      if (r_sel == MW'(i)) w_led_sel = bus.mode_led_in[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_db      <= 1'b0;
      r_db_prev <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= btn_next;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      if (r_sync2 != r_db) begin
        if (r_db_cnt == DW'(DEBOUNCE - 1)) begin
          r_db     <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_auto_cnt <= '0;
    end else if (!auto_en || w_next_req) begin
      r_auto_cnt <= '0;
    end else if (w_run) begin
      r_auto_cnt <= w_auto_req ? '0 : r_auto_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StBlank;
      r_blank_cnt <= '0;
      r_sel       <= '0;
      r_led       <= '0;
      r_rst_n     <= '0;
      r_chg       <= 1'b0;
    end else begin
      r_chg <= 1'b0;
      case (r_state)
        StBlank: begin
          r_led   <= '0;
          r_rst_n <= '0;
          if (r_blank_cnt == BW'(BLANK - 1)) begin
            r_state     <= StRun;
            r_blank_cnt <= '0;
            r_rst_n     <= w_onehot;
          end else begin
            r_blank_cnt <= r_blank_cnt + 1'b1;
          end
        end
        StRun: begin
          if (w_next_req) begin
            r_sel   <= w_sel_next;
            r_state <= StBlank;
            r_chg   <= 1'b1;
            r_led   <= '0;
            r_rst_n <= '0;
          end else begin
            r_led   <= w_led_sel;
            r_rst_n <= w_onehot;
          end
        end
        default: r_state <= StBlank;
      endcase
    end
  end

  assign bus.mode_sel     = r_sel;
  assign bus.led_out      = r_led;
  assign bus.mode_rst_n   = r_rst_n;
  assign bus.mode_changed = r_chg;
endmodule

// File: tb/tb_led_mode_scheduler.sv
// Randomized and directed bench for led_mode_scheduler, checked every cycle against a
// behavioural model of the sequencing rules, plus literal expectations for key scenarios.
module tb_led_mode_scheduler;
  localparam int unsigned NM = 3;
  localparam int unsigned DB = 4;
  localparam int unsigned BL = 3;
  localparam int unsigned AP = 20;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic btn     = 1'b0;
  logic auto_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int chg_cnt  = 0;

  led_mode_scheduler_if #(.NUM_MODES(NM)) bus ();

  led_mode_scheduler #(
    .NUM_MODES  (NM),
    .DEBOUNCE   (DB),
    .BLANK      (BL),
    .AUTO_PERIOD(AP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_next(btn),
    .auto_en (auto_en),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode index, remaining blank cycles, time in current auto period,
  // and a sliding window of synchronized button samples for the debouncer.
  bit          m_s1, m_s2, m_lvl, m_prev;
  bit          m_hist[$];
  int          m_mode, m_blank_left, m_auto;
  logic [7:0]  e_led;
  logic [NM-1:0] e_rst;
  logic        e_chg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: no mode_changed pulse within the cycle limit at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev = 0;
    m_hist.delete();
    m_mode = 0; m_blank_left = BL; m_auto = 0;
    e_led = '0; e_rst = '0; e_chg = 1'b0;
  endtask

  task automatic model_step();
    bit running, breq, areq, req, all_diff;
    running = (m_blank_left == 0);
    breq    = m_lvl && !m_prev;
    areq    = running && auto_en && (m_auto == int'(AP) - 1);
    req     = running && (breq || areq);
    e_chg   = req;
    e_led   = (running && !req) ? bus.mode_led_in[8*m_mode +: 8] : 8'h00;
    e_rst   = ((running && !req) || m_blank_left == 1) ? NM'(1 << m_mode) : '0;
    if (req) begin
      m_mode       = (m_mode + 1) % int'(NM);
      m_blank_left = BL;
      m_auto       = 0;
    end else if (running) begin
      m_auto = auto_en ? (m_auto + 1) % int'(AP) : 0;
    end else begin
      m_blank_left--;
      if (!auto_en) m_auto = 0;
    end
    // Debounced level flips once DB consecutive synced samples disagree with it.
    m_hist.push_back(m_s2);
    if (m_hist.size() > DB) void'(m_hist.pop_front());
    all_diff = (m_hist.size() == DB);
    foreach (m_hist[i]) if (m_hist[i] == m_lvl) all_diff = 0;
    m_prev = m_lvl;
    if (all_diff) m_lvl = m_s2;
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cmp_led_out", bus.led_out, e_led);
        check("cmp_mode_rst_n", bus.mode_rst_n, e_rst);
        check("cmp_mode_sel", bus.mode_sel, m_mode);
        check("cmp_mode_changed", bus.mode_changed, e_chg);
        if (bus.mode_changed === 1'b1) chg_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_chg(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.mode_changed === 1'b1) begin
        n  = i;
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_auto_age(input int age, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (m_blank_left == 0 && m_auto == age) return;
      tick(1);
    end
    fail_timeout("wait_auto_age");
  endtask

  task automatic first_run();
    btn = 1'b0;
    auto_en = 1'b0;
    bus.mode_led_in = 24'h332211;
    tick(1);
    rst_n = 1'b1;
    for (int k = 0; k < int'(BL); k++) begin
      @(negedge clk);
      check("blank_rst_n", bus.mode_rst_n, 0);
      check("blank_led", bus.led_out, 0);
    end
    @(negedge clk);
    check("run_rst_n", bus.mode_rst_n, 3'b001);
    check("run_led_lag", bus.led_out, 0);
    @(negedge clk);
    check("run_led", bus.led_out, 8'h11);
    check("model_run_led", e_led, 8'h11);
    tick(1);
  endtask

  initial begin
    int n, c0, hold;
    bit ok;
    int exp_seq[4];
    exp_seq = '{1, 2, 0, 1};
    bus.mode_led_in = 24'h332211;
    tick(3);
    check("reset_led", bus.led_out, 0);
    check("reset_rst_n", bus.mode_rst_n, 0);
    check("reset_sel", bus.mode_sel, 0);
    check("reset_chg", bus.mode_changed, 0);
    first_run();

    // Auto-cycle from mode 0 with wrap-around.
    auto_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_chg(40, n, ok);
      if (!ok) fail_timeout("auto_pulse");
      else begin
        check("auto_sel", bus.mode_sel, exp_seq[k]);
        if (k > 0) check("auto_period", n, BL + AP);
      end
    end
    auto_en = 1'b0;
    tick(6);

    // Bouncy button then a long hold: one advance, 1 -> 2.
    c0 = chg_cnt;
    for (int i = 0; i < 5; i++) begin
      btn = (i % 2 == 0);
      tick(2);
    end
    btn = 1'b1;
    tick(10);
    check("btn_pulses", chg_cnt - c0, 1);
    check("btn_sel", bus.mode_sel, 2);
    tick(10);
    check("btn_hold_pulses", chg_cnt - c0, 1);
    check("btn_led", bus.led_out, 8'h33);
    check("btn_rst_n", bus.mode_rst_n, 3'b100);
    btn = 1'b0;
    tick(12);
    check("btn_release_pulses", chg_cnt - c0, 1);

    // Button request and auto timeout act on the same edge: single advance 2 -> 0.
    auto_en = 1'b1;
    wait_auto_age(13, 60);
    btn = 1'b1;
    c0 = chg_cnt;
    tick(10);
    check("sim_pulses", chg_cnt - c0, 1);
    check("sim_sel", bus.mode_sel, 0);
    tick(2);
    btn = 1'b0;

    // Button request lands inside the blank after an auto switch: discarded.
    wait_auto_age(15, 60);
    btn = 1'b1;
    c0 = chg_cnt;
    wait_chg(30, n, ok);
    if (!ok) fail_timeout("blank_ignore_pulse");
    auto_en = 1'b0;
    tick(12);
    check("blank_ignore_pulses", chg_cnt - c0, 1);
    check("blank_ignore_sel", bus.mode_sel, 1);
    check("blank_ignore_led", bus.led_out, 8'h22);
    btn = 1'b0;
    tick(10);

    // Reset in the blank right after reaching mode 2.
    btn = 1'b1;
    wait_chg(20, n, ok);
    if (!ok) fail_timeout("mode2_pulse");
    check("mode2_sel", bus.mode_sel, 2);
    #1;
    rst_n = 1'b0;
    btn = 1'b0;
    #1;
    check("midreset_led", bus.led_out, 0);
    check("midreset_rst_n", bus.mode_rst_n, 0);
    check("midreset_sel", bus.mode_sel, 0);
    check("midreset_chg", bus.mode_changed, 0);
    first_run();

    // Randomized traffic checked cycle by cycle against the model.
    hold = 0;
    auto_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      bus.mode_led_in = 24'($urandom);
      if (hold == 0) begin
        btn  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      rst_n = ($urandom_range(0, 1499) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
